// File: rtl/sb_pkg.sv
// Shared types and constants for the simple_bus initiator.
package sb_pkg;

    // Default bus widths; the latched-command struct is sized from these.
    localparam int SB_ADDR_W = 8;
    localparam int SB_DATA_W = 8;

    // Bus mode encoding: bit 0 selects write, bit 1 is reserved (always 0).
    localparam logic [1:0] SB_MODE_READ  = 2'b00;
    localparam logic [1:0] SB_MODE_WRITE = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        START,
        WAIT,
        RESP
    } sb_state_e;

    typedef struct packed {
        logic                 write;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] wdata;
    } sb_cmd_t;

endpackage

// File: rtl/sb_master_engine.sv
// simple_bus initiator: takes one local command, arbitrates with req/gnt,
// issues a single start strobe, waits for rdy and returns a response.
// Every output is registered; REQ and WAIT are bounded by TIMEOUT cycles.
module sb_master_engine
    import sb_pkg::*;
#(
    parameter int ADDR_W  = SB_ADDR_W,
    parameter int DATA_W  = SB_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              req,
    input  logic              gnt,
    output logic              start,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        mode,
    input  logic              rdy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in
);

    localparam int               TMR_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    sb_state_e         state, state_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt, timer_inc;
    sb_cmd_t           cmd_q, cmd_nxt;

    logic              cmd_ready_nxt;
    logic              rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic              rsp_err_nxt;
    logic              req_nxt;
    logic              start_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [1:0]        mode_nxt;
    logic [DATA_W-1:0] data_out_nxt;
    logic              data_oe_nxt;

    // Saturating increment: the phase timer pins at TIMEOUT instead of wrapping.
    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] t);
        if (t == TMR_MAX) begin
            return t;
        end
        return t + 1'b1;
    endfunction

    assign timer_inc = sat_inc(timer);

    // State, timer, latched command and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            cmd_q     <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req       <= 1'b0;
            start     <= 1'b0;
            addr      <= '0;
            mode      <= SB_MODE_READ;
            data_out  <= '0;
            data_oe   <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            cmd_q     <= cmd_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            req       <= req_nxt;
            start     <= start_nxt;
            addr      <= addr_nxt;
            mode      <= mode_nxt;
            data_out  <= data_out_nxt;
            data_oe   <= data_oe_nxt;
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        cmd_nxt       = cmd_q;
        cmd_ready_nxt = cmd_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        req_nxt       = req;
        start_nxt     = 1'b0;
        addr_nxt      = addr;
        mode_nxt      = mode;
        data_out_nxt  = data_out;
        data_oe_nxt   = data_oe;

        case (state)
            IDLE: begin
                cmd_ready_nxt = 1'b1;
                if (cmd_valid) begin
                    cmd_nxt.write = cmd_write;
                    cmd_nxt.addr  = cmd_addr;
                    cmd_nxt.wdata = cmd_wdata;
                    cmd_ready_nxt = 1'b0;
                    req_nxt       = 1'b1;
                    timer_nxt     = '0;
                    state_nxt     = REQ;
                end
            end

            REQ: begin
                // A grant wins over a timeout expiring in the same cycle.
                if (gnt) begin
                    state_nxt    = START;
                    timer_nxt    = '0;
                    start_nxt    = 1'b1;
                    addr_nxt     = cmd_q.addr;
                    mode_nxt     = cmd_q.write ? SB_MODE_WRITE : SB_MODE_READ;
                    data_oe_nxt  = cmd_q.write;
                    data_out_nxt = cmd_q.write ? cmd_q.wdata : '0;
                end else if (timer_inc == TMR_MAX) begin
                    state_nxt     = RESP;
                    timer_nxt     = '0;
                    req_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                end else begin
                    timer_nxt = timer_inc;
                end
            end

            START: begin
                // rdy is deliberately not looked at during the strobe cycle.
                state_nxt = WAIT;
                timer_nxt = '0;
            end

            WAIT: begin
                if (rdy) begin
                    state_nxt     = RESP;
                    timer_nxt     = '0;
                    req_nxt       = 1'b0;
                    data_oe_nxt   = 1'b0;
                    data_out_nxt  = '0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = cmd_q.write ? '0 : data_in;
                end else if (timer_inc == TMR_MAX) begin
                    state_nxt     = RESP;
                    timer_nxt     = '0;
                    req_nxt       = 1'b0;
                    data_oe_nxt   = 1'b0;
                    data_out_nxt  = '0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                end else begin
                    timer_nxt = timer_inc;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    timer_nxt     = '0;
                    rsp_valid_nxt = 1'b0;
                    rsp_err_nxt   = 1'b0;
                    cmd_ready_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sb_master_engine.sv
// Bench for sb_master_engine: a transaction-level timing model predicts the
// cycle of every phase from the grant/ready/backpressure delays it chooses,
// and a per-cycle compare process checks all outputs against that schedule.
module tb_sb_master_engine;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0, cmd_wdata = '0;
    logic       rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [7:0] rsp_rdata;
    logic       req, gnt = 1'b0, start, rdy = 1'b0, data_oe;
    logic [7:0] addr, data_out, data_in = '0;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    sb_master_engine #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .req(req), .gnt(gnt), .start(start), .addr(addr),
        .mode(mode), .rdy(rdy), .data_out(data_out), .data_oe(data_oe),
        .data_in(data_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- schedule of the current transaction ----------------
    bit         model_on = 1'b0;
    bit         s_wr, s_gto, s_err, s_keepg;
    logic [7:0] s_ad, s_wd, s_dn, s_rd;
    int         s_a, s_s, s_w, s_p, s_h, s_g, s_r, s_b;

    // ---------------- monitor for literal checks ----------------
    int         acc_q[$];
    int         req_rise = 0, rsp_rise = 0, start_cyc = 0, start_cnt = 0, oe_cnt = 0;
    logic [7:0] start_addr = '0, oe_last = '0, last_rdata = '0;
    logic [1:0] start_mode = '0;
    logic       last_err = 1'b0, prev_req = 1'b0, prev_rv = 1'b0;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (req && !prev_req) req_rise = cyc;
        if (rsp_valid && !prev_rv) rsp_rise = cyc;
        if (start) begin
            start_cnt++;
            start_cyc  = cyc;
            start_addr = addr;
            start_mode = mode;
        end
        if (data_oe) begin
            oe_cnt++;
            oe_last = data_out;
        end
        if (rsp_valid && rsp_ready) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end
        prev_req = req;
        prev_rv  = rsp_valid;
    end

    // Per-cycle comparison of every output against the predicted schedule.
    logic e_ready, e_req, e_start, e_oe, e_rv;
    always @(negedge clk) begin
        if (model_on && !rst) begin
            e_ready = !(cyc > s_a && cyc <= s_h);
            e_req   = (cyc > s_a && cyc < s_p);
            e_start = !s_gto && cyc == s_s;
            e_oe    = !s_gto && s_wr && cyc >= s_s && cyc < s_p;
            e_rv    = (cyc >= s_p && cyc <= s_h);
            chk("cmd_ready", int'(cmd_ready), int'(e_ready));
            chk("req", int'(req), int'(e_req));
            chk("start", int'(start), int'(e_start));
            chk("data_oe", int'(data_oe), int'(e_oe));
            chk("rsp_valid", int'(rsp_valid), int'(e_rv));
            if (e_start) begin
                chk("addr", int'(addr), int'(s_ad));
                chk("mode", int'(mode), int'({1'b0, s_wr}));
            end
            if (e_oe) chk("data_out", int'(data_out), int'(s_wd));
            if (e_rv) begin
                chk("rsp_rdata", int'(rsp_rdata), int'(s_rd));
                chk("rsp_err", int'(rsp_err), int'(s_err));
            end
        end
    end

    // Drive all inputs for cycle c from the current schedule.
    task automatic drive(input int c);
        cmd_valid = (c == s_a) ? 1'b1 : ((c > s_a) ? 1'($urandom_range(0, 1)) : 1'b0);
        if (c == s_a) begin
            cmd_write = s_wr;
            cmd_addr  = s_ad;
            cmd_wdata = s_wd;
        end else begin
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = 8'($urandom);
            cmd_wdata = 8'($urandom);
        end
        gnt       = !s_gto && (c >= s_a + 1 + s_g) && (c <= s_s || s_keepg);
        rdy       = (s_gto || c < s_s) ? 1'($urandom_range(0, 1)) : (c >= s_s + s_r);
        data_in   = (!s_gto && c == s_w) ? s_dn : 8'($urandom);
        rsp_ready = (c >= s_p + s_b) ? 1'b1 : ((c < s_p) ? 1'($urandom_range(0, 1)) : 1'b0);
    endtask

    // One full transaction; entered and left just after a rising edge.
    task automatic run_txn(input bit wr, input logic [7:0] ad, input logic [7:0] wd,
                           input logic [7:0] dn, input int g, input int r,
                           input int b, input int gap, input bit keepg);
        int cur;
        cur = cyc;
        s_wr = wr; s_ad = ad; s_wd = wd; s_dn = dn;
        s_g = g; s_r = r; s_b = b; s_keepg = keepg;
        s_a = cur + gap;
        if (g < TIMEOUT) begin
            s_gto = 1'b0;
            s_s   = s_a + 2 + g;
            s_w   = s_s + ((r < 1) ? 1 : r);
            if (s_w - s_s <= TIMEOUT) begin
                s_p = s_w + 1; s_err = 1'b0;
            end else begin
                s_p = s_s + 1 + TIMEOUT; s_err = 1'b1;
            end
        end else begin
            s_gto = 1'b1; s_s = -1; s_w = -1;
            s_p   = s_a + 1 + TIMEOUT; s_err = 1'b1;
        end
        s_h  = s_p + b;
        s_rd = (!s_err && !wr) ? dn : 8'h00;
        model_on = 1'b1;
        for (int c = cur; c <= s_h; c++) begin
            if (c != cur) begin
                @(posedge clk); #1;
            end
            drive(c);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int sc0, oe0, a_prev, n;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_rdata", int'(rsp_rdata), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_req", int'(req), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_data_oe", int'(data_oe), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed read: grant 2 cycles after req, rdy 3 cycles after start.
        sc0 = start_cnt; oe0 = oe_cnt;
        run_txn(1'b0, 8'h3C, 8'hEE, 8'hA5, 2, 3, 0, 1, 1'b0);
        chk("rd_start_count", start_cnt - sc0, 1);
        chk("rd_addr", int'(start_addr), 'h3C);
        chk("rd_mode", int'(start_mode), 0);
        chk("rd_rdata", int'(last_rdata), 'hA5);
        chk("rd_err", int'(last_err), 0);
        chk("rd_oe_cycles", oe_cnt - oe0, 0);
        chk("rd_latency", rsp_rise - acc_q[$], 8);

        // Directed write: immediate grant, rdy 1 cycle after start.
        sc0 = start_cnt; oe0 = oe_cnt;
        run_txn(1'b1, 8'h10, 8'h5A, 8'h77, 0, 1, 0, 0, 1'b0);
        chk("wr_start_count", start_cnt - sc0, 1);
        chk("wr_mode", int'(start_mode), 1);
        chk("wr_rdata", int'(last_rdata), 0);
        chk("wr_oe_cycles", oe_cnt - oe0, 2);
        chk("wr_oe_data", int'(oe_last), 'h5A);
        chk("wr_latency", rsp_rise - acc_q[$], 4);

        // Grant timeout: gnt never arrives.
        sc0 = start_cnt;
        run_txn(1'b0, 8'h21, 8'h00, 8'h11, TIMEOUT + 5, 0, 1, 0, 1'b0);
        chk("gto_start_count", start_cnt - sc0, 0);
        chk("gto_err", int'(last_err), 1);
        chk("gto_rdata", int'(last_rdata), 0);
        chk("gto_latency", rsp_rise - req_rise, 15);

        // Response backpressure, then a command right after the handshake.
        run_txn(1'b0, 8'h77, 8'h00, 8'h3E, 1, 2, 4, 0, 1'b1);
        chk("bp_rdata", int'(last_rdata), 'h3E);
        chk("bp_err", int'(last_err), 0);
        a_prev = acc_q[$];
        run_txn(1'b1, 8'h44, 8'hC1, 8'h00, 0, 0, 0, 0, 1'b1);
        chk("bp_next_accept", acc_q[$] - a_prev, 11);

        // Back-to-back with gnt, rdy and rsp_ready already high.
        for (int i = 0; i < 4; i++) begin
            a_prev = acc_q[$];
            run_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                    0, 0, 0, 0, 1'b1);
            chk("b2b_interval", acc_q[$] - a_prev, 5);
        end

        // Ready timeout on a write.
        oe0 = oe_cnt;
        run_txn(1'b1, 8'h55, 8'hAA, 8'h00, 0, TIMEOUT + 3, 0, 0, 1'b0);
        chk("wto_err", int'(last_err), 1);
        chk("wto_rdata", int'(last_rdata), 0);
        chk("wto_latency", rsp_rise - start_cyc, 16);
        chk("wto_oe_cycles", oe_cnt - oe0, 16);

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                    $urandom_range(0, TIMEOUT + 2), $urandom_range(0, TIMEOUT + 2),
                    $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a write's WAIT phase.
        model_on  = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'hC3; cmd_wdata = 8'h99;
        gnt = 1'b1; rdy = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!start && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rstw_start_seen", int'(start), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstw_pre_oe", int'(data_oe), 1);
        chk("rstw_pre_req", int'(req), 1);
        rst = 1'b1;
        #1;
        chk("rstw_req", int'(req), 0);
        chk("rstw_start", int'(start), 0);
        chk("rstw_data_oe", int'(data_oe), 0);
        chk("rstw_cmd_ready", int'(cmd_ready), 1);
        chk("rstw_rsp_valid", int'(rsp_valid), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; rdy = 1'b1; rsp_ready = 1'b1; gnt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rstw_post_rsp_valid", int'(rsp_valid), 0);
            chk("rstw_post_cmd_ready", int'(cmd_ready), 1);
            chk("rstw_post_req", int'(req), 0);
        end
        @(posedge clk); #1;

        // Recovery after the reset.
        run_txn(1'b0, 8'h5E, 8'h00, 8'h81, 1, 1, 1, 0, 1'b0);
        chk("recover_rdata", int'(last_rdata), 'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_master_engine.md
Name: sb_master_engine

Overview:
- Initiator-side controller for the simple_bus protocol. It is the counterpart of the memory responder, which grants on req and serves slaveRead/slaveWrite on start.
- Accepts one local read/write command at a time over a valid/ready port and arbitrates for the bus with req/gnt.
- Issues a one-cycle start with addr/mode, waits for rdy, then returns read data or completion status on a response port.
- Sits between a CPU-side command source and the simple_bus master modport. The shared data line is split into data_out/data_oe/data_in at this boundary.

Parameters:
- ADDR_W, 8, bus address width.
- DATA_W, 8, bus data width.
- TIMEOUT, 15, maximum cycles spent in REQ or in WAIT before the transaction is aborted with error. Must be ≥1.

Ports:
- clk  input  1  bus clock, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when valid&ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  target address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed when valid&ready.
- rsp_rdata  output  DATA_W  read data; 0 for writes.
- rsp_err  output  1  transaction timed out.
- req  output  1  bus request.
- gnt  input  1  bus grant.
- start  output  1  transfer strobe.
- addr  output  ADDR_W  bus address.
- mode  output  2  bus mode.
- rdy  input  1  responder completion.
- data_out  output  DATA_W  write data driven to bus.
- data_oe  output  1  data_out enable.
- data_in  input  DATA_W  bus data sampled on reads.

Behaviour:
- Reset (async, immediate): state = IDLE, timer = 0.
  - Outputs: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, req=0, start=0, addr=0, mode=0, data_out=0, data_oe=0.
  - A reset asserted mid-transaction drops req/start/data_oe at once and produces no response.
- All outputs are registered.
- Mode encoding: mode[0] = 0 read, 1 write; mode[1] = 0 always.
- IDLE: cmd_ready=1. On cmd_valid: latch addr, mode, wdata; go to REQ; req=1 from the next cycle.
- REQ: cmd_ready=0, req=1, timer counts up each cycle.
  - gnt sampled 1 → START; timer cleared.
  - timer reaches TIMEOUT with gnt still 0 → RESP with rsp_err=1; req=0.
- START: exactly one cycle with start=1; addr and mode are valid.
  - Write: data_oe=1 and data_out=wdata from this cycle onward.
  - Next state is always WAIT. rdy is ignored in this cycle.
- WAIT: start=0; req, addr, mode and data_oe stay held. Deassertion of gnt is ignored. Timer counts.
  - rdy sampled 1 → RESP. A read captures data_in into rsp_rdata in the same edge. req=0 and data_oe=0 from the next cycle.
  - timer reaches TIMEOUT → RESP with rsp_err=1, rsp_rdata=0; req=0, data_oe=0.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are stable until the handshake.
  - On rsp_ready → IDLE; rsp_valid=0 and rsp_err=0 next cycle.
- Cycle timing:
  - Minimum 5 cycles per transaction (IDLE, REQ, START, WAIT, RESP).
  - With gnt and rdy already high and rsp_ready=1, the next command is accepted 5 cycles after the previous one.
- Timer width: $clog2(TIMEOUT+1). It saturates and never wraps. It is cleared on every state entry.
- gnt and rdy both high in REQ: only gnt is acted on.
- rdy high while in IDLE or REQ: ignored.

Decomposition:
- Package sb_pkg:
  - SB_MODE_READ = 2'b00, SB_MODE_WRITE = 2'b01.
  - Typedef sb_state_e {IDLE, REQ, START, WAIT, RESP}.
  - Typedef sb_cmd_t {write, addr, wdata}.
- Single module; no sub-module needed.

Test Plan:
- Read: cmd addr=8'h3C, write=0; gnt high 2 cycles after req; rdy 3 cycles after start with data_in=8'hA5 → exactly one start pulse with addr=8'h3C, mode=2'b00; rsp_rdata=8'hA5, rsp_err=0; data_oe never 1.
- Write: cmd addr=8'h10, wdata=8'h5A; gnt immediate; rdy 1 cycle after start → start with mode=2'b01; data_oe=1 and data_out=8'h5A from the start cycle to the rdy cycle; rsp_rdata=0.
- Grant timeout: gnt held 0 → rsp_err=1 exactly TIMEOUT cycles after REQ entry; start never pulses; req drops.
- Response backpressure: rsp_ready held 0 for 4 cycles after rsp_valid → rsp_rdata stable, cmd_ready=0 throughout; next command is accepted the cycle after the handshake.
- Reset mid-WAIT on a write: rst asserted → req, start, data_oe = 0 immediately; after release cmd_ready=1 and no rsp_valid appears.
- Back-to-back: gnt=rdy=rsp_ready=1 always, cmd_valid constant → a command is accepted every 5 cycles.
